// File: rtl/sti_pixel_packer.sv
// rtl/sti_pixel_packer.sv - packs a serial bit stream MSB-first into bytes and writes them to pixel memory
module sti_pixel_packer #(
  parameter logic [7:0] FILL_VALUE = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       so_valid,
  input  logic       so_data,
  input  logic       pi_end,
  output logic       pixel_wr,
  output logic [7:0] pixel_addr,
  output logic [7:0] pixel_dataout,
  output logic       pixel_finish,
  output logic       err_partial
);

  typedef enum logic [1:0] {IDLE, SHIFT, FILL, DONE} state_t;

  state_t     state, state_n;
  logic [7:0] shreg, shreg_n;
  logic [2:0] bitcnt, bitcnt_n;
  logic [8:0] wptr, wptr_n;
  logic       wr_n;
  logic [7:0] addr_n;
  logic [7:0] data_n;
  logic       finish_n;
  logic       err_n;
  logic [7:0] shifted;

  assign shifted = {shreg[6:0], so_data};

  // State and output registers; every output is registered so writes appear one cycle after issue.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      shreg         <= 8'h00;
      bitcnt        <= 3'd0;
      wptr          <= 9'd0;
      pixel_wr      <= 1'b0;
      pixel_addr    <= 8'h00;
      pixel_dataout <= 8'h00;
      pixel_finish  <= 1'b0;
      err_partial   <= 1'b0;
    end else begin
      state         <= state_n;
      shreg         <= shreg_n;
      bitcnt        <= bitcnt_n;
      wptr          <= wptr_n;
      pixel_wr      <= wr_n;
      pixel_addr    <= addr_n;
      pixel_dataout <= data_n;
      pixel_finish  <= finish_n;
      err_partial   <= err_n;
    end
  end

  // Next-state logic: shifting, byte write issue, burst-end handling and padding.
  always_comb begin
    state_n  = state;
    shreg_n  = shreg;
    bitcnt_n = bitcnt;
    wptr_n   = wptr;
    wr_n     = 1'b0;
    addr_n   = pixel_addr;
    data_n   = pixel_dataout;
    err_n    = err_partial;
    // Finish goes high on the edge that closes the cycle in which address 255 is written.
    finish_n = pixel_finish | (pixel_wr & (pixel_addr == 8'hFF));

    case (state)
      IDLE: begin
        if (so_valid) begin
          shreg_n  = shifted;
          bitcnt_n = bitcnt + 3'd1;
          state_n  = SHIFT;
        end
      end
      SHIFT: begin
        if (wptr[8]) begin
          // Memory is full: any further bits are dropped rather than wrapping to address 0.
          bitcnt_n = 3'd0;
          state_n  = DONE;
        end else if (so_valid) begin
          shreg_n  = shifted;
          bitcnt_n = bitcnt + 3'd1;
          if (bitcnt == 3'd7) begin
            wr_n   = 1'b1;
            addr_n = wptr[7:0];
            data_n = shifted;
            wptr_n = wptr + 9'd1;
          end
        end else begin
          // Burst end: leftover bits are discarded and flagged.
          if (bitcnt != 3'd0) begin
            err_n = 1'b1;
          end
          bitcnt_n = 3'd0;
          state_n  = pi_end ? FILL : IDLE;
        end
      end
      FILL: begin
        if (wptr[8]) begin
          state_n = DONE;
        end else begin
          wr_n   = 1'b1;
          addr_n = wptr[7:0];
          data_n = FILL_VALUE;
          wptr_n = wptr + 9'd1;
          if (wptr[7:0] == 8'hFF) begin
            state_n = DONE;
          end
        end
      end
      DONE: begin
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: doc/sti_pixel_packer.md
# sti_pixel_packer

Downstream stage of the serial transmit interface. Consumes the `so_valid`/`so_data` bit stream and packs it MSB-first into bytes. Writes each byte to the 256-entry pixel memory at consecutive addresses. When the frame ends (`pi_end` seen at the end of a burst), it pads the remaining addresses with a fill value and raises `pixel_finish`.

## Interface
Parameters:
- `FILL_VALUE`, default 8'h00: byte written to every unwritten address during padding.

Ports:
- `clk`  input  1  single clock; all state changes on rising edge.
- `reset`  input  1  asynchronous, active-high; clears all state and outputs immediately.
- `so_valid`  input  1  high while a serial burst is in progress; bursts are contiguous.
- `so_data`  input  1  serial bit, sampled when `so_valid`=1.
- `pi_end`  input  1  frame-end flag, sampled only on the first cycle with `so_valid`=0 after a burst.
- `pixel_wr`  output  1  one-cycle write strobe per byte.
- `pixel_addr`  output  8  write address; valid while `pixel_wr`=1.
- `pixel_dataout`  output  8  write data; valid while `pixel_wr`=1.
- `pixel_finish`  output  1  sticky; high once address 255 has been written.
- `err_partial`  output  1  sticky; a burst ended with a bit count that is not a multiple of 8.

Reset values: all outputs 0, write pointer 0, bit counter 0, state IDLE.

## Operation
- Internal registers:
  - `shreg[7:0]` shift register.
  - `bitcnt[2:0]` bit counter.
  - `wptr[8:0]` write pointer; bit 8 set means the memory is full.
- States:
  - IDLE: waiting for a burst. `so_valid`=1 shifts the first bit and moves to SHIFT.
  - SHIFT: each cycle with `so_valid`=1, `shreg <= {shreg[6:0], so_data}` and `bitcnt` increments.
    - On the 8th bit (`bitcnt`=7 at sampling), a write is issued next cycle with data `{shreg[6:0], so_data}`.
  - FILL: write `FILL_VALUE` at `wptr` every cycle and increment `wptr`.
  - DONE: no further writes; `pixel_finish`=1; all inputs ignored until reset.
- SHIFT, first cycle with `so_valid`=0 (burst end):
  - If `bitcnt`≠0: the partial bits are discarded, `bitcnt` is cleared and `err_partial` is set.
  - If `pi_end`=1 and `wptr`<256: go to FILL.
  - If `pi_end`=1 and `wptr`=256: go to DONE.
  - If `pi_end`=0: go to IDLE.
- Write issue (registered):
  - `pixel_wr <= 1`, `pixel_addr <= wptr[7:0]`, `pixel_dataout <= byte`, `wptr <= wptr+1`.
  - `pixel_wr` returns to 0 the following cycle unless another write is issued (FILL issues back-to-back).
- Wrap and full:
  - When the write to address 255 is issued in SHIFT, `wptr` becomes 256 and the state becomes DONE on the next edge.
  - Bits still arriving after that point are ignored and never wrap to address 0.
  - In FILL, the write to 255 is the last; the next state is DONE.
- `pi_end`=1 while in IDLE, or during a burst, has no effect.
- Reset asserted mid-burst or mid-fill aborts immediately:
  - Outputs return to their reset values.
  - Memory contents already written are not the block's concern.

## Timing
- Latency from 8th bit sampled (edge N) to `pixel_wr`=1: one cycle, i.e. high during cycle N+1.
- Minimum spacing between SHIFT writes is 8 cycles; no write collisions occur.
- The final byte's write coincides with the burst-end cycle. The state moves to FILL at the end of that cycle, and the first fill write appears the following cycle at the next address.
- FILL throughput: one write per cycle. From `wptr`=k, the last write occurs 256−k cycles after entering FILL.
- `pixel_finish` rises on the edge after the cycle in which address 255 was written, and stays high until reset.
- `err_partial` rises on the edge ending the burst-end cycle.

## Test plan
- Single byte then end:
  - Stimulus: burst 10110001, then `so_valid`=0 with `pi_end`=1.
  - Required: write addr 0 data 8'hB1, then fill writes addr 1..255 with 8'h00 on consecutive cycles, then `pixel_finish`=1.
- Multi-burst frame:
  - Stimulus: bursts of 16 bits (16'hA55A) and 32 bits (32'h01234567) with `pi_end`=0, then an 8-bit burst 8'hFF with `pi_end`=1.
  - Required: addr 0..6 = A5,5A,01,23,45,67,FF, then padding from addr 7.
- Partial burst:
  - Stimulus: 12-bit burst 12'hABC, `pi_end`=0.
  - Required: one write 8'hAB at addr 0, `err_partial`=1, next burst starts at addr 1 with a clean bit counter.
- Overflow:
  - Stimulus: 260 bytes streamed with `pi_end`=0.
  - Required: exactly 256 writes at addr 0..255, no write to addr 0 again, `pixel_finish`=1 after addr 255.
- Reset mid-fill:
  - Stimulus: assert `reset` asynchronously during FILL at addr 40.
  - Required: `pixel_wr`, `pixel_addr`, `pixel_finish` and `err_partial` go to 0 immediately; a following frame restarts at addr 0.
- Fill value parameter:
  - Stimulus: `FILL_VALUE`=8'h7E, one byte 8'h00 with `pi_end`=1.
  - Required: addr 1..255 all receive 8'h7E.
